// File: rtl/bus_merge_arb_2.sv
// bus_merge_arb_2: two-source arbitrated merge into a 2-entry {tag, data} FIFO.
// Each cycle at most one source is granted. The winning word is queued together
// with its source index, so a downstream 2-way demux can route the response back.
// Optional feature macro: MERGE_ARB_ROUND_ROBIN_EN
//   defined   -> a registered priority pointer alternates contention winners
//   undefined -> fixed priority: source 0 always wins contention
module bus_merge_arb_2 #(
    parameter int unsigned NrOfBits = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [NrOfBits-1:0] MuxIn_0,
    input  logic                Valid_0,
    output logic                Ready_0,
    input  logic [NrOfBits-1:0] MuxIn_1,
    input  logic                Valid_1,
    output logic                Ready_1,
    output logic [NrOfBits-1:0] MuxOut,
    output logic                OutSel,
    output logic                OutValid,
    input  logic                OutReady
);

    localparam int unsigned EntryBits = NrOfBits + 1;
    localparam int unsigned CountBits = 2;
    localparam logic [CountBits-1:0] CountFull  = CountBits'(2);
    localparam logic [CountBits-1:0] CountEmpty = CountBits'(0);

    // Entry layout: {tag, data}; the tag is the source index of the stored word.
    logic [EntryBits-1:0] entry0;
    logic [EntryBits-1:0] entry1;
    logic [EntryBits-1:0] headEntry;
    logic [EntryBits-1:0] pushEntry;

    logic                 wrPtr;
    logic                 rdPtr;
    logic [CountBits-1:0] count;
    logic [CountBits-1:0] countNext;

    logic                 isFull;
    logic                 isEmpty;
    logic                 prioPtr;
    logic                 grant1;
    logic                 accept;
    logic                 push;
    logic                 pop;

    assign isFull  = (count == CountFull);
    assign isEmpty = (count == CountEmpty);

`ifdef MERGE_ARB_ROUND_ROBIN_EN
    // Priority pointer: after a transfer from source i, source 1-i gets preference.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prioPtr <= 1'b0;
        end else if (push) begin
            prioPtr <= ~grant1;
        end
    end
`else
    // Fixed priority: source 0 wins every contention.
    assign prioPtr = 1'b0;
`endif

    // Grant and accept: a lone valid source wins, contention is resolved by prioPtr.
    always_comb begin
        grant1  = 1'b0;
        accept  = 1'b0;
        Ready_0 = 1'b0;
        Ready_1 = 1'b0;
        grant1  = Valid_1 & (~Valid_0 | prioPtr);
        // Reset gates acceptance so no source sees a ready while the queue is held clear.
        accept  = ~Reset & Enable & ~isFull & (Valid_0 | Valid_1);
        Ready_0 = accept & ~grant1;
        Ready_1 = accept & grant1;
    end

    // Accept always implies a transfer from the granted, valid source.
    assign push = accept;
    assign pop  = OutValid & OutReady;

    // Winning word plus its tag.
    always_comb begin
        pushEntry = '0;
        if (grant1) begin
            pushEntry = {1'b1, MuxIn_1};
        end else begin
            pushEntry = {1'b0, MuxIn_0};
        end
    end

    // Storage: write the granted entry at the write pointer.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            entry0 <= '0;
            entry1 <= '0;
        end else if (push) begin
            if (wrPtr) begin
                entry1 <= pushEntry;
            end else begin
                entry0 <= pushEntry;
            end
        end
    end

    // Write pointer advances on push.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr <= 1'b0;
        end else if (push) begin
            wrPtr <= ~wrPtr;
        end
    end

    // Read pointer advances on pop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdPtr <= 1'b0;
        end else if (pop) begin
            rdPtr <= ~rdPtr;
        end
    end

    // Occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + CountBits'(1);
            2'b01:   countNext = count - CountBits'(1);
            default: countNext = count;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= CountEmpty;
        end else begin
            count <= countNext;
        end
    end

    // Head presentation: zeros when empty so stale entries never leak out.
    always_comb begin
        headEntry = '0;
        OutValid  = ~isEmpty;
        if (!isEmpty) begin
            headEntry = rdPtr ? entry1 : entry0;
        end
        MuxOut = headEntry[NrOfBits-1:0];
        OutSel = headEntry[EntryBits-1];
    end

endmodule

// File: tb/tb_bus_merge_arb_2.sv
// Directed bench for bus_merge_arb_2 at NrOfBits = 8.
// Expectations follow the build: MERGE_ARB_ROUND_ROBIN_EN selects round-robin ones.
module tb_bus_merge_arb_2;

    localparam int unsigned W = 8;

    logic         Clock;
    logic         Reset;
    logic         Enable;
    logic [W-1:0] MuxIn_0;
    logic         Valid_0;
    logic         Ready_0;
    logic [W-1:0] MuxIn_1;
    logic         Valid_1;
    logic         Ready_1;
    logic [W-1:0] MuxOut;
    logic         OutSel;
    logic         OutValid;
    logic         OutReady;

    int nChecks = 0;
    int nFails  = 0;

`ifdef MERGE_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    bus_merge_arb_2 #(.NrOfBits(W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .MuxIn_0 (MuxIn_0),
        .Valid_0 (Valid_0),
        .Ready_0 (Ready_0),
        .MuxIn_1 (MuxIn_1),
        .Valid_1 (Valid_1),
        .Ready_1 (Ready_1),
        .MuxOut  (MuxOut),
        .OutSel  (OutSel),
        .OutValid(OutValid),
        .OutReady(OutReady)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        Enable   = 1'b1;
        Valid_0  = 1'b1;
        Valid_1  = 1'b1;
        MuxIn_0  = 8'h5A;
        MuxIn_1  = 8'h3C;
        OutReady = 1'b0;

        // Reset held with both sources valid.
        #2;
        checkVal("rst_ready0", 16'(Ready_0), 16'h0);
        checkVal("rst_ready1", 16'(Ready_1), 16'h0);
        checkVal("rst_outvalid", 16'(OutValid), 16'h0);
        checkVal("rst_muxout", 16'(MuxOut), 16'h0);
        checkVal("rst_outsel", 16'(OutSel), 16'h0);
        tick();
        checkVal("rst_hold_outvalid", 16'(OutValid), 16'h0);

        // First word after release: one-cycle latency, no bypass.
        Reset   = 1'b0;
        Valid_1 = 1'b0;
        MuxIn_0 = 8'hA5;
        #1;
        checkVal("first_ready0", 16'(Ready_0), 16'h1);
        checkVal("first_nobypass", 16'(OutValid), 16'h0);
        tick();
        Valid_0 = 1'b0;
        #1;
        checkVal("first_outvalid", 16'(OutValid), 16'h1);
        checkVal("first_muxout", 16'(MuxOut), 16'hA5);
        checkVal("first_outsel", 16'(OutSel), 16'h0);
        OutReady = 1'b1;
        tick();
        checkVal("first_drained", 16'(OutValid), 16'h0);

        // Continuous dual contention with OutReady high.
        applyReset();
        Valid_0  = 1'b1;
        Valid_1  = 1'b1;
        MuxIn_0  = 8'h10;
        MuxIn_1  = 8'h20;
        OutReady = 1'b1;
        #1;
        checkVal("cont_ready0_c0", 16'(Ready_0), 16'h1);
        checkVal("cont_ready1_c0", 16'(Ready_1), 16'h0);
        for (int k = 0; k < 4; k++) begin
            logic expSel;
            tick();
            expSel = RoundRobin ? 1'((k % 2) != 0) : 1'b0;
            checkVal($sformatf("cont_outsel_%0d", k), 16'(OutSel), 16'(expSel));
            checkVal($sformatf("cont_muxout_%0d", k), 16'(MuxOut), expSel ? 16'h20 : 16'h10);
            checkVal($sformatf("cont_outvalid_%0d", k), 16'(OutValid), 16'h1);
            checkVal($sformatf("cont_ready1_%0d", k), 16'(Ready_1),
                     RoundRobin ? 16'(~expSel) : 16'h0);
        end
        Valid_0 = 1'b0;
        Valid_1 = 1'b0;
        tick();
        checkVal("cont_drained", 16'(OutValid), 16'h0);

        // Full boundary: no push-through while full, even when popping.
        applyReset();
        OutReady = 1'b0;
        Valid_0  = 1'b1;
        MuxIn_0  = 8'h01;
        #1;
        checkVal("full_ready_a", 16'(Ready_0), 16'h1);
        tick();
        MuxIn_0 = 8'h02;
        #1;
        checkVal("full_ready_b", 16'(Ready_0), 16'h1);
        tick();
        MuxIn_0 = 8'h03;
        #1;
        checkVal("full_ready0", 16'(Ready_0), 16'h0);
        checkVal("full_ready1", 16'(Ready_1), 16'h0);
        checkVal("full_head", 16'(MuxOut), 16'h01);
        OutReady = 1'b1;
        #1;
        checkVal("full_no_pushthrough", 16'(Ready_0), 16'h0);
        tick();
        OutReady = 1'b0;
        #1;
        checkVal("full_after_pop_head", 16'(MuxOut), 16'h02);
        checkVal("full_resume_ready", 16'(Ready_0), 16'h1);
        tick();
        Valid_0  = 1'b0;
        OutReady = 1'b1;
        #1;
        checkVal("full_drain_head2", 16'(MuxOut), 16'h02);
        tick();
        checkVal("full_drain_head3", 16'(MuxOut), 16'h03);
        tick();
        checkVal("full_drain_empty", 16'(OutValid), 16'h0);
        checkVal("full_empty_muxout", 16'(MuxOut), 16'h0);

        // Enable low: no acceptance, queued words still drain in order.
        applyReset();
        OutReady = 1'b0;
        Valid_0  = 1'b1;
        MuxIn_0  = 8'h55;
        tick();
        MuxIn_0 = 8'h66;
        tick();
        Enable  = 1'b0;
        Valid_1 = 1'b1;
        MuxIn_1 = 8'h77;
        #1;
        checkVal("en_ready0", 16'(Ready_0), 16'h0);
        checkVal("en_ready1", 16'(Ready_1), 16'h0);
        OutReady = 1'b1;
        #1;
        checkVal("en_head1", 16'(MuxOut), 16'h55);
        tick();
        checkVal("en_head2", 16'(MuxOut), 16'h66);
        checkVal("en_ready1_drain", 16'(Ready_1), 16'h0);
        tick();
        checkVal("en_empty", 16'(OutValid), 16'h0);

        // Mid-operation asynchronous reset discards queued words.
        Enable   = 1'b1;
        Valid_1  = 1'b0;
        OutReady = 1'b0;
        MuxIn_0  = 8'h77;
        tick();
        MuxIn_0 = 8'h88;
        tick();
        Valid_0 = 1'b0;
        #1;
        checkVal("mid_queued", 16'(OutValid), 16'h1);
        #1;
        Reset = 1'b1;
        #1;
        checkVal("mid_rst_outvalid", 16'(OutValid), 16'h0);
        checkVal("mid_rst_muxout", 16'(MuxOut), 16'h0);
        #1;
        Reset = 1'b0;
        tick();
        checkVal("mid_post_outvalid", 16'(OutValid), 16'h0);
        Valid_1 = 1'b1;
        MuxIn_1 = 8'hAB;
        #1;
        checkVal("mid_ready1", 16'(Ready_1), 16'h1);
        tick();
        Valid_1 = 1'b0;
        #1;
        checkVal("mid_new_muxout", 16'(MuxOut), 16'hAB);
        checkVal("mid_new_outsel", 16'(OutSel), 16'h1);
        OutReady = 1'b1;
        tick();
        checkVal("mid_final_empty", 16'(OutValid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
